// File: rtl/obj_manager.sv
// Scrolling object manager: spawns objects into slots, scans one slot per cycle
// after each vsync edge to move, animate and collision-test them against the player.
module obj_manager #(
  parameter int NUM_OBJ        = 8,
  parameter int SCREEN_WIDTH   = 1024,
  parameter int CHAR_WIDTH     = 20,
  parameter int CHAR_HEIGHT    = 20,
  parameter int OBJ_HEIGHT     = 20,
  parameter int FRAME_DIV_LOG2 = 3,
  parameter int WRAP_EN        = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    vsync,
  input  logic [3:0]              speed,
  input  logic [9:0]              p_vpos,
  input  logic                    spawn_valid,
  input  logic [1:0]              spawn_id,
  input  logic [9:0]              spawn_vpos,
  output logic                    spawn_ready,
  output logic [26*NUM_OBJ-1:0]   obj_bus,
  output logic [7:0]              score,
  output logic                    collect,
  output logic                    hit,
  output logic                    busy,
  output logic                    overrun
);
  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  typedef enum logic [1:0] {ST_STOP, ST_IDLE, ST_SCAN} state_t;

  state_t                    r_state, w_next;
  logic [NUM_OBJ-1:0][25:0]  r_slot;
  logic [NUM_OBJ-1:0]        r_skip;
  logic [IW-1:0]             r_idx;
  logic [FRAME_DIV_LOG2-1:0] r_fdiv;
  logic [7:0]                r_score;
  logic                      r_vs_prev, r_collect, r_hit, r_overrun;

  logic          w_vs_pulse, w_has_empty, w_accept, w_proc, w_last;
  logic [IW-1:0] w_free_idx;
  logic [25:0]   w_cur, w_new;
  logic [2:0]    w_frame, w_fnew;
  logic [1:0]    w_id;
  logic [10:0]   w_hpos, w_hnew, w_spd, w_vpos, w_pv;
  logic          w_live, w_coll, w_hitobj, w_keep;
  logic [8:0]    w_sum;
  logic [7:0]    w_score_nxt;

  assign w_vs_pulse  = vsync & ~r_vs_prev;
  assign spawn_ready = (r_state == ST_IDLE) && w_has_empty;
  assign w_accept    = spawn_valid && spawn_ready;
  assign w_proc      = (r_state == ST_SCAN) && !stop;
  assign w_last      = (r_idx == IW'(NUM_OBJ - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_STOP: if (start)      w_next = ST_IDLE;
      ST_IDLE: if (w_vs_pulse) w_next = ST_SCAN;
      ST_SCAN: if (w_last)     w_next = ST_IDLE;
      default:                 w_next = ST_STOP;
    endcase
    if (stop) w_next = ST_STOP;
  end

  // lowest-index empty slot wins
  always_comb begin
    w_has_empty = 1'b0;
    w_free_idx  = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (r_slot[i] == '0) begin
        w_has_empty = 1'b1;
        w_free_idx  = IW'(i);
      end
    end
  end

  assign w_cur   = r_slot[r_idx];
  assign w_frame = w_cur[25:23];
  assign w_id    = w_cur[22:21];
  assign w_hpos  = w_cur[20:10];
  assign w_vpos  = {1'b0, w_cur[9:0]};
  assign w_pv    = {1'b0, p_vpos};
  assign w_spd   = {7'd0, speed};

  // a slot spawned on the scan-start edge waits for the next scan
  assign w_live   = (w_cur != '0) && !r_skip[r_idx];
  assign w_coll   = (w_hpos < 11'(CHAR_WIDTH)) &&
                    (w_vpos < w_pv + 11'(CHAR_HEIGHT)) &&
                    (w_vpos + 11'(OBJ_HEIGHT) > w_pv);
  assign w_hitobj = w_live && w_coll;

  always_comb begin
    w_keep = 1'b1;
    w_hnew = w_hpos;
    if (speed == 4'd0)        w_hnew = w_hpos;
    else if (w_hpos > w_spd)  w_hnew = w_hpos - w_spd;
    else if (WRAP_EN != 0)    w_hnew = 11'(SCREEN_WIDTH - 1);
    else                      w_keep = 1'b0;
    w_fnew = (r_fdiv == '0) ? w_frame + 3'd1 : w_frame;
    w_new  = w_cur;
    if (w_live) begin
      if (w_coll || !w_keep) w_new = '0;
      else                   w_new = {w_fnew, w_id, w_hnew, w_cur[9:0]};
    end
  end

  always_comb begin
    w_sum       = {1'b0, r_score} + ((w_id == 2'd2) ? 9'd2 : 9'd1);
    w_score_nxt = r_score;
    case (w_id)
      2'd0, 2'd2: w_score_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];
      2'd1:       w_score_nxt = (r_score == 8'd0) ? 8'd0 : r_score - 8'd1;
      default:    w_score_nxt = r_score;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_STOP;
      r_slot    <= '0;
      r_skip    <= '0;
      r_idx     <= '0;
      r_fdiv    <= '0;
      r_score   <= '0;
      r_vs_prev <= 1'b0;
      r_collect <= 1'b0;
      r_hit     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_vs_prev <= vsync;
      r_collect <= 1'b0;
      r_hit     <= 1'b0;
      if (r_state == ST_SCAN && w_vs_pulse) r_overrun <= 1'b1;
      if (r_state == ST_IDLE)
        r_skip <= (w_accept && w_vs_pulse) ? (NUM_OBJ'(1) << w_free_idx) : '0;
      if (w_proc) begin
        r_slot[r_idx] <= w_new;
        if (w_hitobj) begin
          r_score   <= w_score_nxt;
          r_collect <= (w_id != 2'd1);
          r_hit     <= (w_id == 2'd1);
        end
        if (w_last) begin
          r_idx  <= '0;
          r_fdiv <= r_fdiv + 1'b1;
        end else begin
          r_idx  <= r_idx + 1'b1;
        end
      end else begin
        r_idx <= '0;
      end
      if (w_accept)
        r_slot[w_free_idx] <= {3'b000, spawn_id, 11'(SCREEN_WIDTH - 1), spawn_vpos};
    end
  end

  assign obj_bus = r_slot;
  assign score   = r_score;
  assign collect = r_collect;
  assign hit     = r_hit;
  assign busy    = (r_state == ST_SCAN);
  assign overrun = r_overrun;
endmodule

// File: tb/tb_obj_manager.sv
// Bench for obj_manager: a removing and a wrapping instance share stimulus and are
// compared against a slot-list model after every scan.
module tb_obj_manager;
  localparam int NO = 8;

  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, vsync = 1'b0;
  logic spawn_valid = 1'b0;
  logic [3:0] speed = '0;
  logic [9:0] p_vpos = '0, spawn_vpos = '0;
  logic [1:0] spawn_id = '0;
  logic [26*NO-1:0] bus [2];
  logic [7:0] score [2];
  logic sr [2], col [2], hit [2], busy [2], ovr [2];

  obj_manager #(.NUM_OBJ(NO), .WRAP_EN(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .vsync(vsync),
    .speed(speed), .p_vpos(p_vpos), .spawn_valid(spawn_valid), .spawn_id(spawn_id),
    .spawn_vpos(spawn_vpos), .spawn_ready(sr[0]), .obj_bus(bus[0]), .score(score[0]),
    .collect(col[0]), .hit(hit[0]), .busy(busy[0]), .overrun(ovr[0]));

  obj_manager #(.NUM_OBJ(NO), .WRAP_EN(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .vsync(vsync),
    .speed(speed), .p_vpos(p_vpos), .spawn_valid(spawn_valid), .spawn_id(spawn_id),
    .spawn_vpos(spawn_vpos), .spawn_ready(sr[1]), .obj_bus(bus[1]), .score(score[1]),
    .collect(col[1]), .hit(hit[1]), .busy(busy[1]), .overrun(ovr[1]));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int mon_busy = 0;
  int mon_col [2] = '{0, 0};
  int mon_hit [2] = '{0, 0};

  always @(negedge clock) begin
    if (busy[0]) mon_busy++;
    for (int d = 0; d < 2; d++) begin
      if (col[d]) mon_col[d]++;
      if (hit[d]) mon_hit[d]++;
    end
  end

  // reference model
  logic [25:0] m_slot [2][NO];
  bit  m_fresh [2][NO];
  int  m_score [2];
  int  e_col [2], e_hit [2];
  int  m_fdiv;
  bit  m_idle, m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic m_clear();
    for (int d = 0; d < 2; d++) begin
      m_score[d] = 0;
      for (int i = 0; i < NO; i++) begin
        m_slot[d][i] = '0;
        m_fresh[d][i] = 1'b0;
      end
    end
    m_fdiv = 0; m_idle = 1'b0; m_ovr = 1'b0;
  endtask

  function automatic int m_low_empty(input int d);
    for (int i = 0; i < NO; i++) if (m_slot[d][i] == '0) return i;
    return -1;
  endfunction

  task automatic m_spawn(input int d, input logic [1:0] id, input logic [9:0] vp, input bit fresh);
    int k;
    k = m_low_empty(d);
    if (m_idle && k >= 0) begin
      m_slot[d][k] = {3'b000, id, 11'd1023, vp};
      m_fresh[d][k] = fresh;
    end
  endtask

  task automatic m_scan();
    int h, v, id, f, nh, pv, spd;
    bit coll;
    pv = int'(p_vpos);
    spd = int'(speed);
    for (int d = 0; d < 2; d++) begin
      e_col[d] = 0; e_hit[d] = 0;
      for (int i = 0; i < NO; i++) begin
        if (m_fresh[d][i] || m_slot[d][i] == '0) continue;
        f = int'(m_slot[d][i][25:23]); id = int'(m_slot[d][i][22:21]);
        h = int'(m_slot[d][i][20:10]); v = int'(m_slot[d][i][9:0]);
        coll = (h < 20) && (v < pv + 20) && (v + 20 > pv);
        if (coll) begin
          m_slot[d][i] = '0;
          if (id == 1) begin
            e_hit[d]++;
            m_score[d] = (m_score[d] > 0) ? m_score[d] - 1 : 0;
          end else begin
            e_col[d]++;
            if (id == 0) m_score[d] = m_score[d] + 1;
            if (id == 2) m_score[d] = m_score[d] + 2;
            if (m_score[d] > 255) m_score[d] = 255;
          end
          continue;
        end
        if (spd == 0) nh = h;
        else if (h > spd) nh = h - spd;
        else if (d == 1) nh = 1023;
        else begin
          m_slot[d][i] = '0;
          continue;
        end
        if (m_fdiv == 0) f = (f + 1) % 8;
        m_slot[d][i] = {3'(f), 2'(id), 11'(nh), 10'(v)};
      end
      for (int i = 0; i < NO; i++) m_fresh[d][i] = 1'b0;
    end
    m_fdiv = (m_fdiv + 1) % 8;
  endtask

  function automatic bit m_all_empty();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NO; i++) if (m_slot[d][i] != '0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NO; i++) chk({tag, "_slot"}, 32'(bus[d][26*i +: 26]), 32'(m_slot[d][i]));
      chk({tag, "_score"}, 32'(score[d]), m_score[d]);
      chk({tag, "_overrun"}, 32'(ovr[d]), 32'(m_ovr));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 0; stop = 0; vsync = 0; spawn_valid = 0; speed = '0;
    tick(); tick();
    m_clear();
    check_all("reset");
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(sr[d]), 0); chk("reset_busy", 32'(busy[d]), 0);
      chk("reset_collect", 32'(col[d]), 0); chk("reset_hit", 32'(hit[d]), 0);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_pulse();
    start = 1'b1; tick(); start = 1'b0; m_idle = 1'b1;
  endtask

  task automatic spawn_cyc(input logic [1:0] id, input logic [9:0] vp);
    spawn_valid = 1'b1; spawn_id = id; spawn_vpos = vp;
    for (int d = 0; d < 2; d++)
      chk("spawn_ready", 32'(sr[d]), 32'(m_idle && (m_low_empty(d) >= 0)));
    tick();
    for (int d = 0; d < 2; d++) m_spawn(d, id, vp, 1'b0);
    spawn_valid = 1'b0;
  endtask

  task automatic run_scan(input bit co, input bit second_edge);
    int b0, n;
    int c0 [2], h0 [2];
    b0 = mon_busy;
    for (int d = 0; d < 2; d++) begin c0[d] = mon_col[d]; h0[d] = mon_hit[d]; end
    if (co) begin
      spawn_valid = 1'b1;
      for (int d = 0; d < 2; d++) m_spawn(d, spawn_id, spawn_vpos, 1'b1);
    end
    vsync = 1'b1; tick(); vsync = 1'b0; spawn_valid = 1'b0;
    if (second_edge) begin
      tick(); tick(); vsync = 1'b1; tick(); vsync = 1'b0;
      m_ovr = 1'b1;
    end
    n = 0;
    while (busy[0] && n < 40) begin tick(); n++; end
    chk("scan_end", 32'(busy[0]), 0);
    chk("scan_end_b", 32'(busy[1]), 0);
    tick();
    m_scan();
    chk("busy_cycles", mon_busy - b0, NO);
    for (int d = 0; d < 2; d++) begin
      chk("collect_cnt", mon_col[d] - c0[d], e_col[d]);
      chk("hit_cnt", mon_hit[d] - h0[d], e_hit[d]);
    end
    check_all("scan");
  endtask

  task automatic wave(input int n, input logic [1:0] id);
    speed = 4'd15;
    for (int k = 0; k < n; k++) spawn_cyc(id, p_vpos);
    for (int s = 0; s < 80 && !m_all_empty(); s++) run_scan(1'b0, 1'b0);
  endtask

  initial begin
    int h0, c0, v;
    do_reset();

    // STOP ignores spawns and vsync
    spawn_cyc(2'd0, 10'd50);
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    chk("stop_busy", 32'(busy[0]), 0);
    check_all("stop");

    // fill all slots, ninth request refused
    start_pulse();
    p_vpos = 10'd600;
    for (int i = 0; i < 9; i++) spawn_cyc(2'(i), 10'(300 + i));
    check_all("fill");
    chk("fill_hpos7", 32'(bus[0][26*7+10 +: 11]), 1023);
    chk("fill_ready_low", 32'(sr[0]), 0);

    // second vsync edge inside the scan
    speed = 4'd3;
    run_scan(1'b0, 1'b1);
    chk("overrun_set", 32'(ovr[0]), 1);
    tick(); tick(); tick();
    chk("no_rescan", 32'(busy[0]), 0);

    // scroll to the left edge: remove vs wrap
    do_reset(); start_pulse();
    p_vpos = 10'd500;
    spawn_cyc(2'd0, 10'd100);
    speed = 4'd14; repeat (72) run_scan(1'b0, 1'b0);
    speed = 4'd10; run_scan(1'b0, 1'b0);
    chk("scroll_h5", 32'(bus[0][10 +: 11]), 5);
    speed = 4'd4; run_scan(1'b0, 1'b0);
    chk("scroll_h1_0", 32'(bus[0][10 +: 11]), 1);
    chk("scroll_h1_1", 32'(bus[1][10 +: 11]), 1);
    run_scan(1'b0, 1'b0);
    chk("scroll_removed", 32'(bus[0][0 +: 26]), 0);
    chk("scroll_wrapped", 32'(bus[1][10 +: 11]), 1023);

    // coin + bonus collide, hazard passes under
    do_reset(); start_pulse();
    p_vpos = 10'd600;
    spawn_cyc(2'd2, 10'd85);  speed = 4'd7; run_scan(1'b0, 1'b0);
    spawn_cyc(2'd0, 10'd110); speed = 4'd5; run_scan(1'b0, 1'b0);
    spawn_cyc(2'd1, 10'd125);
    speed = 4'd12; repeat (84) run_scan(1'b0, 1'b0);
    chk("coll_pre_haz", 32'(bus[0][26*2+10 +: 11]), 15);
    p_vpos = 10'd100; speed = 4'd4;
    h0 = mon_hit[0]; c0 = mon_col[0];
    run_scan(1'b0, 1'b0);
    chk("coll_score", 32'(score[0]), 3);
    chk("coll_collects", mon_col[0] - c0, 2);
    chk("coll_hits", mon_hit[0] - h0, 0);
    chk("coll_haz_h", 32'(bus[0][26*2+10 +: 11]), 11);

    // reset in the 4th scan cycle
    spawn_cyc(2'd0, 10'd400);
    vsync = 1'b1; tick(); vsync = 1'b0; tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    m_clear();
    check_all("midreset");
    chk("midreset_busy", 32'(busy[0]), 0);
    tick(); reset_n = 1'b1; tick();
    spawn_cyc(2'd0, 10'd100);
    check_all("nostart");
    start_pulse();
    spawn_cyc(2'd0, 10'd100);
    check_all("restart");

    // saturation high
    do_reset(); start_pulse();
    p_vpos = 10'd200;
    repeat (15) wave(8, 2'd2);
    wave(7, 2'd2);
    chk("sat_254", 32'(score[0]), 254);
    wave(2, 2'd2);
    chk("sat_255", 32'(score[0]), 255);

    // saturation low
    do_reset(); start_pulse();
    h0 = mon_hit[0];
    wave(1, 2'd1);
    chk("sat_0", 32'(score[0]), 0);
    chk("sat_0_hit", mon_hit[0] - h0, 1);

    // randomized traffic
    do_reset(); start_pulse();
    p_vpos = 10'd300;
    for (int r = 0; r < 250; r++) begin
      if ($urandom_range(0, 24) == 0) begin
        stop = 1'b1; tick(); stop = 1'b0; m_idle = 1'b0;
        spawn_cyc(2'($urandom_range(0, 3)), 10'd77);
        start_pulse();
      end
      if ($urandom_range(0, 19) == 0) p_vpos = 10'($urandom_range(20, 700));
      repeat ($urandom_range(0, 2)) begin
        v = int'(p_vpos) + int'($urandom_range(0, 50)) - 25;
        if (v < 1) v = 1;
        spawn_cyc(2'($urandom_range(0, 3)), 10'(v));
      end
      speed = 4'($urandom_range(0, 15));
      spawn_id = 2'($urandom_range(0, 3));
      v = int'(p_vpos) + int'($urandom_range(0, 50)) - 25;
      if (v < 1) v = 1;
      spawn_vpos = 10'(v);
      run_scan($urandom_range(0, 3) == 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/obj_manager.md
OBJ_MANAGER -- requirements
Module: obj_manager

Interface
REQ-001 Parameter NUM_OBJ, default 8: number of object slots (2..16).
REQ-002 Parameter SCREEN_WIDTH, default 1024: respawn horizontal position plus one.
REQ-003 Parameters CHAR_WIDTH 20, CHAR_HEIGHT 20, OBJ_HEIGHT 20: collision box sizes in pixels.
REQ-004 Parameter FRAME_DIV_LOG2, default 3: an object's animation frame advances once every 2^FRAME_DIV_LOG2 scans.
REQ-005 Parameter WRAP_EN, default 0: 1 = an object reaching the left edge wraps to the right edge; 0 = it is removed.
REQ-006 clock  in  1  system clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  reset; asynchronous, active-low.
REQ-008 start  in  1  leaves STOP state (one-cycle pulse).
REQ-009 stop  in  1  returns to STOP state.
REQ-010 vsync  in  1  raw VGA vsync level.
REQ-011 speed  in  4  pixels moved per scan.
REQ-012 p_vpos  in  10  player vertical position.
REQ-013 spawn_valid  in  1  spawn request.
REQ-014 spawn_id  in  2  identity of the object to spawn: 0 = coin (+1), 1 = hazard, 2 = bonus (+2), 3 = reserved (+0).
REQ-015 spawn_vpos  in  10  vertical position of the spawned object (must be nonzero).
REQ-016 spawn_ready  out  1  a spawn can be accepted this cycle.
REQ-017 obj_bus  out  26*NUM_OBJ  slot i occupies bits [26i+25:26i].
  - Slot word: [25:23] frame, [22:21] identity, [20:10] hpos, [9:0] vpos.
  - An all-zero word means the slot is empty.
REQ-018 score  out  8  saturating score.
REQ-019 collect  out  1  one-cycle pulse per collectable collision.
REQ-020 hit  out  1  one-cycle pulse per hazard collision.
REQ-021 busy  out  1  high while in SCAN state.
REQ-022 overrun  out  1  sticky; set when a vsync edge arrives while in SCAN state.

Function
REQ-023 States SHALL be STOP, IDLE and SCAN.
  - STOP->IDLE on start.
  - IDLE->SCAN on the vsync rising-edge pulse.
  - SCAN->IDLE the cycle after slot NUM_OBJ-1 is processed.
  - stop forces STOP from any state; stop has priority over start.
REQ-024 The vsync rising edge SHALL be detected by a registered previous-level compare, giving one pulse per edge.
REQ-025 SCAN SHALL process exactly one slot per cycle, index 0..NUM_OBJ-1 in order, so busy is high for NUM_OBJ cycles.
REQ-026 Empty slots SHALL be skipped unchanged; they still consume their cycle.
REQ-027 Collision test (11-bit unsigned, no underflow), all three conditions required:
  - hpos < CHAR_WIDTH
  - vpos < p_vpos + CHAR_HEIGHT
  - vpos + OBJ_HEIGHT > p_vpos
REQ-028 On collision the slot SHALL be cleared to zero, with no move or frame update, and score/pulse handled by identity:
  - id 0: score +1, collect pulse
  - id 2: score +2, collect pulse
  - id 1: score -1, hit pulse
  - id 3: no score change, collect pulse
REQ-029 Score SHALL saturate at 255 and at 0.
REQ-030 Without collision, movement:
  - if hpos > speed: hpos <= hpos - speed;
  - else if WRAP_EN = 1: hpos <= SCREEN_WIDTH-1;
  - else: slot cleared.
REQ-031 Frame divider: a FRAME_DIV_LOG2-bit counter increments once per completed scan. During a scan with counter == 0, frame of every moved slot <= frame+1 (mod 8).
REQ-032 spawn_ready SHALL be high only in IDLE with at least one empty slot.
REQ-033 A spawn is accepted when spawn_valid and spawn_ready are both high. The lowest-index empty slot is then loaded with {3'b000, spawn_id, SCREEN_WIDTH-1, spawn_vpos} on the next edge.
REQ-034 If a vsync pulse and an accepted spawn coincide in IDLE, the spawn SHALL complete and the scan SHALL start in the same cycle. The new slot is first processed in the following scan.
REQ-035 A vsync pulse during SCAN SHALL NOT restart the scan; it sets overrun, which clears only on reset.
REQ-036 In STOP, slots and score SHALL hold; spawn_ready, collect, hit and busy are 0.
REQ-037 speed = 0 SHALL leave hpos unchanged; frame and collision still apply.

Reset
REQ-038 While reset_n is low, the block SHALL hold these values:
  - state STOP
  - all slots 0
  - score 0
  - frame divider 0
  - edge register 0
  - all outputs 0
REQ-039 Reset asserted mid-SCAN SHALL abort the scan immediately, with no partial score update retained.

Verification
REQ-040 Spawn fill: NUM_OBJ=8, IDLE, spawn_valid held for 9 cycles with ids 0,1,2,... -> slots 0..7 filled with hpos 1023; spawn_ready low after the 8th accept; the 9th request is not taken.
REQ-041 Scroll/remove: slot hpos=5, speed=4, WRAP_EN=0, two vsync edges -> hpos 1, then slot cleared. Same stimulus with WRAP_EN=1 -> hpos 1, then 1023.
REQ-042 Collision: p_vpos=100; coin at hpos=10, vpos=110; bonus at hpos=3, vpos=85; hazard at hpos=15, vpos=125 (no overlap) -> score 3, two collect pulses, hazard moves to 11, no hit pulse.
REQ-043 Saturation: score=254, two bonus collisions -> score 255. Score=0, hazard collision -> score 0, one hit pulse.
REQ-044 Overrun/timing: NUM_OBJ=8, second vsync edge 3 cycles after the first -> busy high exactly 8 cycles, single scan, overrun = 1.
REQ-045 Reset: reset_n low during cycle 4 of a scan -> all slots 0, score 0, state STOP; a start pulse is required before any spawn is accepted.
